spartan_sram_slave: RTL and testbench
=====================================

# spartan_sram_slave

Spartan bus target endpoint that terminates request packets arriving on the master channel (SpMBUS/SpMVLD/SpMRDY) and returns response packets on the slave channel (SpSBUS/SpSVLD/SpSRDY). It implements a word-addressed on-chip memory and is the responder paired with any Spartan initiator or sync gasket. It hangs directly off the B side of a sync gasket or an interconnect port.

## Interface
- BWIDTH, 64, payload width; only 64 supported (bus is BWIDTH+2 bits)
- DEPTH_LOG2, 8, log2 of memory depth in 64-bit words
- CLK  input  1  clock; all logic on rising edge
- RST  input  1  reset; **synchronous, active-high**
- SpMBUS  input  BWIDTH+2  request beat; [65:64] tag, [63:0] payload
- SpMVLD  input  1  request beat valid
- SpMRDY  output  1  request beat accepted when SpMVLD&SpMRDY
- SpSBUS  output  BWIDTH+2  response beat; [65:64] tag, [63:0] payload
- SpSVLD  output  1  response beat valid
- SpSRDY  input  1  downstream accepts response beat

## Operation
- Tag encoding, both channels:
  - 2'b01 first
  - 2'b00 middle
  - 2'b10 last
  - 2'b11 single
- Header payload fields:
  - [63] WRITE
  - [39:32] LEN (beats-1)
  - [31:0] byte address
  - Word index = addr[DEPTH_LOG2+2:3]; addr[2:0] ignored.
  - Index increments per beat and wraps modulo 2^DEPTH_LOG2.
- Read request: header tagged single, WRITE=0.
  - Response is LEN+1 data beats.
  - Tags: first/middle…/last; single when LEN=0.
- Write request: header tagged first, WRITE=1, followed by LEN+1 data beats, final one tagged last.
  - Response is one ack beat: tag single, payload[0]=error, other bits 0.
- States:
  - IDLE: SpMRDY=1. An accepted header decodes as follows:
    - read+single → RDATA.
    - write+first → WDATA.
    - write+single (no data) → WACK with error=1.
    - read+first → DRAIN with error=1.
    - Beat tagged middle/last in IDLE: accepted and discarded; stay IDLE.
  - WDATA: SpMRDY=1. Each accepted beat writes memory and decrements the remaining count.
    - Beat tagged last with count==0 → WACK, error=0.
    - Beat tagged last with count>0 → WACK, error=1; beats already written are retained.
    - Count exhausted on a non-last beat → DRAIN, error=1.
    - Beat tagged first/single in WDATA is treated as data.
  - DRAIN: SpMRDY=1. Beats are discarded until the last/single beat is accepted → WACK.
  - WACK: SpMRDY=0, SpSVLD=1 holding the ack. On SpSRDY → IDLE.
  - RDATA: SpMRDY=0, SpSVLD=1. On each SpSRDY, advance to the next beat; after the final beat → IDLE.
- Memory contents are not reset.

## Timing
- Reset values while RST=1 and the cycle after:
  - SpSVLD=0, SpSBUS=0, SpMRDY=0, state=IDLE.
  - SpMRDY rises the first cycle after RST deasserts.
- SpSBUS and SpSVLD are registered. SpMRDY is decoded from state register only, with no combinational path from SpSRDY or SpMVLD.
- Read latency: header accepted at edge N → beat 0 valid after edge N+1.
  - With SpSRDY held high, one beat per cycle.
  - Memory is read one beat ahead into the output register.
- Write ack latency: last beat accepted at edge N → ack valid after edge N+1.
- While SpSVLD=1 and SpSRDY=0, SpSBUS is held stable.
- Back-to-back: a new header may be accepted in the cycle after the final response beat handshake. No request overlaps an outstanding response.
- RST mid-packet: abort immediately, drop any pending response, return to IDLE. Partial writes stay in memory.

## Structure
- spartan_pkg holds:
  - tag constants (TAG_FIRST/MID/LAST/SINGLE)
  - header field positions (HDR_WRITE_BIT, HDR_LEN_LSB/MSB, HDR_ADDR_MSB)
  - ack error bit index
  - state enum
- One sub-module, spartan_sram_mem:
  - DEPTH_LOG2-addressed 64-bit register array
  - synchronous write
  - registered read with read-enable
  - no reset on contents

## Test plan
- Write addr 0x10, LEN=3, data 0xA0..0xA3 → ack tag 11, payload 0. Then read addr 0x10, LEN=3 → beats 0xA0(01), 0xA1(00), 0xA2(00), 0xA3(10).
- Read LEN=0 at word 2^DEPTH_LOG2-1 after writing 0x55 there; also read LEN=1 at the same word → beats mem[255], mem[0] (wrap).
- Write LEN=3 with last on 2nd data beat → ack error=1; words 0-1 updated, words 2-3 unchanged.
- Write LEN=0 followed by 3 data beats, last on 3rd → one ack error=1; SpMRDY stays 1 through drain; only word 0 written.
- Read LEN=7 with SpSRDY toggled randomly → 8 beats in order, SpSBUS stable while stalled, SpMRDY=0 throughout.
- Assert RST mid-read (beat 3 of 8) → SpSVLD=0 on the next cycle. A new read then returns correct data from beat 0.

Source files
------------

// File: rtl/spartan_sram_slave_pkg.sv
// Shared constants and types for the Spartan SRAM target endpoint.
// Tag encodings, header field positions and the controller state enum.
package spartan_pkg;

    localparam logic [1:0] TAG_FIRST  = 2'b01;
    localparam logic [1:0] TAG_MID    = 2'b00;
    localparam logic [1:0] TAG_LAST   = 2'b10;
    localparam logic [1:0] TAG_SINGLE = 2'b11;

    localparam int HDR_WRITE_BIT = 63;
    localparam int HDR_LEN_MSB   = 39;
    localparam int HDR_LEN_LSB   = 32;
    localparam int HDR_ADDR_MSB  = 31;
    localparam int ACK_ERR_BIT   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_DRAIN,
        ST_WACK,
        ST_RDATA
    } state_t;

    // LAST and SINGLE both close a packet; both have tag[1] set.
    function automatic logic is_end(input logic [1:0] tag);
        return tag[1];
    endfunction

endpackage

// File: rtl/spartan_sram_slave_if.sv
// Spartan request (master) and response (slave) channels.
// The master modport drives requests; the slave modport is the target endpoint.
interface spartan_sram_slave_if #(
    parameter int BWIDTH = 64
);
    logic [BWIDTH+1:0] SpMBUS;
    logic              SpMVLD;
    logic              SpMRDY;
    logic [BWIDTH+1:0] SpSBUS;
    logic              SpSVLD;
    logic              SpSRDY;

    modport master (
        output SpMBUS, SpMVLD, SpSRDY,
        input  SpMRDY, SpSBUS, SpSVLD
    );

    modport slave (
        input  SpMBUS, SpMVLD, SpSRDY,
        output SpMRDY, SpSBUS, SpSVLD
    );
endinterface

// File: rtl/spartan_sram_mem.sv
// Word-addressed storage: synchronous write, registered read gated by rd_en.
// The read register holds its value while rd_en is low; contents are never reset.
module spartan_sram_mem #(
    parameter int DEPTH_LOG2 = 8,
    parameter int W          = 64
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [W-1:0]          wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [W-1:0]          rd_data
);
    logic [W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/spartan_sram_slave.sv
// Spartan bus target: decodes request packets, reads/writes the word memory
// and returns read data bursts or a single write ack on the response channel.
module spartan_sram_slave
    import spartan_pkg::*;
#(
    parameter int BWIDTH     = 64,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    spartan_sram_slave_if.slave  sp
);
    localparam int AW = DEPTH_LOG2;

    state_t            state;
    logic [7:0]        cnt;
    logic [AW-1:0]     idx;
    logic              err;
    logic              ld;
    logic [BWIDTH+1:0] sbus;
    logic              svld;
    logic              mrdy;

    logic [1:0]        in_tag;
    logic [BWIDTH-1:0] in_pl;
    logic              acc;
    logic              out_adv;
    logic              hdr_w;
    logic [7:0]        hdr_len;
    logic [AW-1:0]     hdr_idx;
    logic [BWIDTH-1:0] ack_pl;

    logic              wr_en;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [BWIDTH-1:0] rd_data;

    assign in_tag  = sp.SpMBUS[BWIDTH+1:BWIDTH];
    assign in_pl   = sp.SpMBUS[BWIDTH-1:0];
    assign acc     = sp.SpMVLD & mrdy;
    assign out_adv = svld & sp.SpSRDY;
    assign hdr_w   = in_pl[HDR_WRITE_BIT];
    assign hdr_len = in_pl[HDR_LEN_MSB:HDR_LEN_LSB];
    assign hdr_idx = in_pl[AW+2:3];

    assign sp.SpMRDY = mrdy;
    assign sp.SpSBUS = sbus;
    assign sp.SpSVLD = svld;

    always_comb begin
        ack_pl              = '0;
        ack_pl[ACK_ERR_BIT] = err;
    end

    assign wr_en = acc && (state == ST_WDATA);

    // The read port always runs one beat ahead of the output register.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = idx;
        if (state == ST_IDLE && acc && in_tag == TAG_SINGLE && !hdr_w) begin
            rd_en   = 1'b1;
            rd_addr = hdr_idx;
        end else if (state == ST_RDATA) begin
            if (ld)           rd_en = (cnt != 8'd0);
            else if (out_adv) rd_en = (cnt > 8'd1);
        end
    end

    spartan_sram_mem #(.DEPTH_LOG2(DEPTH_LOG2), .W(BWIDTH)) u_mem (
        .clk     (CLK),
        .wr_en   (wr_en),
        .wr_addr (idx),
        .wr_data (in_pl),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            err   <= 1'b0;
            ld    <= 1'b0;
            sbus  <= '0;
            svld  <= 1'b0;
            mrdy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    mrdy <= 1'b1;
                    if (acc) begin
                        if (in_tag == TAG_SINGLE && !hdr_w) begin
                            state <= ST_RDATA;
                            idx   <= hdr_idx + AW'(1);
                            cnt   <= hdr_len;
                            ld    <= 1'b1;
                            mrdy  <= 1'b0;
                        end else if (in_tag == TAG_FIRST && hdr_w) begin
                            state <= ST_WDATA;
                            idx   <= hdr_idx;
                            cnt   <= hdr_len;
                        end else if (in_tag == TAG_SINGLE) begin
                            state <= ST_WACK;
                            err   <= 1'b1;
                            ld    <= 1'b1;
                            mrdy  <= 1'b0;
                        end else if (in_tag == TAG_FIRST) begin
                            state <= ST_DRAIN;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (acc) begin
                        idx <= idx + AW'(1);
                        cnt <= cnt - 8'd1;
                        if (in_tag == TAG_LAST) begin
                            state <= ST_WACK;
                            err   <= (cnt != 8'd0);
                            ld    <= 1'b1;
                            mrdy  <= 1'b0;
                        end else if (cnt == 8'd0) begin
                            state <= ST_DRAIN;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (acc && is_end(in_tag)) begin
                        state <= ST_WACK;
                        ld    <= 1'b1;
                        mrdy  <= 1'b0;
                    end
                end
                ST_WACK: begin
                    if (ld) begin
                        sbus <= {TAG_SINGLE, ack_pl};
                        svld <= 1'b1;
                        ld   <= 1'b0;
                    end else if (out_adv) begin
                        svld  <= 1'b0;
                        mrdy  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_RDATA: begin
                    // cnt counts beats not yet loaded into the output register.
                    if (ld) begin
                        sbus <= {(cnt == 8'd0) ? TAG_SINGLE : TAG_FIRST, rd_data};
                        svld <= 1'b1;
                        ld   <= 1'b0;
                        if (cnt != 8'd0) idx <= idx + AW'(1);
                    end else if (out_adv) begin
                        if (cnt == 8'd0) begin
                            svld  <= 1'b0;
                            mrdy  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            sbus <= {(cnt == 8'd1) ? TAG_LAST : TAG_MID, rd_data};
                            cnt  <= cnt - 8'd1;
                            if (cnt > 8'd1) idx <= idx + AW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spartan_sram_slave.sv
// Directed bench for spartan_sram_slave: write/read bursts, wrap, error acks,
// response stalls and reset mid-burst, all against hand-computed values.
module tb_spartan_sram_slave;
    import spartan_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [63:0] exp_d [8];

    spartan_sram_slave_if #(.BWIDTH(64)) bus ();

    spartan_sram_slave #(.BWIDTH(64), .DEPTH_LOG2(8)) dut (
        .CLK (clk),
        .RST (rst),
        .sp  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic w, input logic [7:0] len, input logic [31:0] addr);
        return {w, 23'd0, len, addr};
    endfunction

    task automatic send(input logic [65:0] b);
        int n = 0;
        @(negedge clk);
        bus.SpMBUS = b;
        bus.SpMVLD = 1'b1;
        while (!bus.SpMRDY && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.SpMRDY) chk("send_timeout", 66'(bus.SpMRDY), 66'd1);
        @(posedge clk);
        #1 bus.SpMVLD = 1'b0;
    endtask

    task automatic recv(output logic [65:0] b);
        int n = 0;
        @(negedge clk);
        while (!bus.SpSVLD && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.SpSVLD) chk("recv_timeout", 66'(bus.SpSVLD), 66'd1);
        b = bus.SpSBUS;
        bus.SpSRDY = 1'b1;
        @(posedge clk);
        #1 bus.SpSRDY = 1'b0;
    endtask

    task automatic wr_burst(input string nm, input logic [31:0] addr, input int n,
                            input logic [63:0] base, input bit lat);
        logic [65:0] b;
        send({TAG_FIRST, hdr(1'b1, 8'(n - 1), addr)});
        for (int i = 0; i < n; i++)
            send({(i == n - 1) ? TAG_LAST : TAG_MID, base + 64'(i)});
        if (lat) begin
            @(negedge clk);
            chk({nm, "_lat0"}, 66'(bus.SpSVLD), 66'd0);
            @(negedge clk);
            chk({nm, "_lat1"}, 66'(bus.SpSVLD), 66'd1);
        end
        recv(b);
        chk({nm, "_ack"}, b, {TAG_SINGLE, 64'd0});
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] addr, input int n, input bit lat);
        logic [65:0] b;
        logic [1:0]  t;
        send({TAG_SINGLE, hdr(1'b0, 8'(n - 1), addr)});
        if (lat) begin
            @(negedge clk);
            chk({nm, "_lat0"}, 66'(bus.SpSVLD), 66'd0);
            @(negedge clk);
            chk({nm, "_lat1"}, 66'(bus.SpSVLD), 66'd1);
        end
        for (int i = 0; i < n; i++) begin
            recv(b);
            t = (n == 1) ? TAG_SINGLE : (i == 0) ? TAG_FIRST : (i == n - 1) ? TAG_LAST : TAG_MID;
            chk($sformatf("%s_b%0d", nm, i), b, {t, exp_d[i]});
        end
    endtask

    initial begin
        logic [65:0] b;
        logic [65:0] held;
        bit          stalled;
        bit          stab_bad;
        bit          mrdy_hi;
        int          k;
        int          cyc;

        rst        = 1'b1;
        bus.SpMBUS = '0;
        bus.SpMVLD = 1'b0;
        bus.SpSRDY = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_svld", 66'(bus.SpSVLD), 66'd0);
        chk("rst_sbus", bus.SpSBUS, 66'd0);
        chk("rst_mrdy", 66'(bus.SpMRDY), 66'd0);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("rst_mrdy_rise", 66'(bus.SpMRDY), 66'd1);

        // basic burst write then read back, words 2..5
        wr_burst("wr10", 32'h10, 4, 64'hA0, 1'b1);
        for (int i = 0; i < 4; i++) exp_d[i] = 64'hA0 + 64'(i);
        rd_chk("rd10", 32'h10, 4, 1'b1);

        // word 255 then wrap to word 0
        send({TAG_FIRST, hdr(1'b1, 8'd1, 32'h7F8)});
        send({TAG_MID, 64'h55});
        send({TAG_LAST, 64'h77});
        recv(b);
        chk("wrwrap_ack", b, {TAG_SINGLE, 64'd0});
        exp_d[0] = 64'h55;
        rd_chk("rd255_len0", 32'h7F8, 1, 1'b0);
        exp_d[0] = 64'h55;
        exp_d[1] = 64'h77;
        rd_chk("rd255_wrap", 32'h7F8, 2, 1'b0);

        // early last: words 8,9 overwritten, 10,11 keep C2,C3
        wr_burst("wr40", 32'h40, 4, 64'hC0, 1'b0);
        send({TAG_FIRST, hdr(1'b1, 8'd3, 32'h40)});
        send({TAG_MID, 64'hB0});
        send({TAG_LAST, 64'hB1});
        recv(b);
        chk("early_last_ack", b, {TAG_SINGLE, 64'd1});
        exp_d[0] = 64'hB0;
        exp_d[1] = 64'hB1;
        exp_d[2] = 64'hC2;
        exp_d[3] = 64'hC3;
        rd_chk("rd40", 32'h40, 4, 1'b0);

        // overrun: LEN=0 with three beats, only word 16 written
        wr_burst("wr80", 32'h80, 2, 64'hE0, 1'b0);
        send({TAG_FIRST, hdr(1'b1, 8'd0, 32'h80)});
        send({TAG_MID, 64'hD0});
        chk("drain_mrdy0", 66'(bus.SpMRDY), 66'd1);
        send({TAG_MID, 64'hD1});
        chk("drain_mrdy1", 66'(bus.SpMRDY), 66'd1);
        send({TAG_LAST, 64'hD2});
        recv(b);
        chk("overrun_ack", b, {TAG_SINGLE, 64'd1});
        exp_d[0] = 64'hD0;
        exp_d[1] = 64'hE1;
        rd_chk("rd80", 32'h80, 2, 1'b0);

        // stray mid beat in IDLE is swallowed
        send({TAG_MID, 64'h1234});
        chk("idle_discard_mrdy", 66'(bus.SpMRDY), 66'd1);

        // LEN=7 with random response stalls
        wr_burst("wr100", 32'h100, 8, 64'hF0, 1'b0);
        send({TAG_SINGLE, hdr(1'b0, 8'd7, 32'h100)});
        k = 0; cyc = 0; stalled = 0; stab_bad = 0; mrdy_hi = 0; held = '0;
        while (k < 8 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            mrdy_hi |= bus.SpMRDY;
            if (stalled && bus.SpSBUS !== held) stab_bad = 1;
            if (bus.SpSVLD) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.SpSRDY = 1'b1;
                    chk($sformatf("stall_b%0d", k), bus.SpSBUS,
                        {(k == 0) ? TAG_FIRST : (k == 7) ? TAG_LAST : TAG_MID, 64'hF0 + 64'(k)});
                    k++;
                    stalled = 0;
                end else begin
                    bus.SpSRDY = 1'b0;
                    stalled = 1;
                    held = bus.SpSBUS;
                end
            end else begin
                bus.SpSRDY = 1'b0;
                stalled = 0;
            end
        end
        @(posedge clk);
        #1 bus.SpSRDY = 1'b0;
        chk("stall_beats", 66'(k), 66'd8);
        chk("stall_stable", 66'(stab_bad), 66'd0);
        chk("stall_mrdy", 66'(mrdy_hi), 66'd0);

        // reset while beat 3 of 8 is pending
        send({TAG_SINGLE, hdr(1'b0, 8'd7, 32'h100)});
        for (int i = 0; i < 3; i++) begin
            recv(b);
            chk($sformatf("prerst_b%0d", i), b,
                {(i == 0) ? TAG_FIRST : TAG_MID, 64'hF0 + 64'(i)});
        end
        @(negedge clk);
        chk("prerst_b3", bus.SpSBUS, {TAG_MID, 64'hF3});
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_svld", 66'(bus.SpSVLD), 66'd0);
        chk("midrst_mrdy", 66'(bus.SpMRDY), 66'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_mrdy", 66'(bus.SpMRDY), 66'd1);
        for (int i = 0; i < 8; i++) exp_d[i] = 64'hF0 + 64'(i);
        rd_chk("postrst_rd", 32'h100, 8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
